// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, mode codes and magnitude helper for the Sobel stream
// Contents:
//   PIX_W_DEF        default pixel width
//   GRAD_W           gradient width for the default pixel width (pixel width + 3)
//   MODE_MAG/THR     runtime output mode codes
//   grad_width()     gradient width for any pixel width
//   sat_abs_sum()    |gx| + |gy| clamped to the largest pixel value
package sobel_pkg;

  localparam int PIX_W_DEF = 8;

  function automatic int grad_width(input int pix_w);
    // Worst case |Gx| is 4 * (2^pix_w - 1), which needs two extra magnitude bits plus sign.
    return pix_w + 3;
  endfunction

  localparam int GRAD_W = grad_width(PIX_W_DEF);

  localparam logic MODE_MAG = 1'b0;
  localparam logic MODE_THR = 1'b1;

  // Gradients arrive sign-extended to 32 bits so one helper serves every pixel width.
  function automatic logic [31:0] sat_abs_sum(input logic signed [31:0] gx,
                                              input logic signed [31:0] gy,
                                              input int pix_w);
    logic [31:0] ax;
    logic [31:0] ay;
    logic [31:0] sum;
    logic [31:0] lim;
    ax  = gx[31] ? -gx : gx;
    ay  = gy[31] ? -gy : gy;
    sum = ax + ay;
    lim = (32'd1 << pix_w) - 32'd1;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// rtl/sobel_kernel.sv - combinational 3x3 Sobel gradient, magnitude and threshold
// Ports:
//   p00..p22  window pixels, row then column, top-left first
//   mode      MODE_MAG: saturated |Gx|+|Gy|; MODE_THR: all-ones when magnitude >= thresh
//   thresh    threshold used in MODE_THR
//   result    PIX_W output pixel
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] p00,
  input  logic [PIX_W-1:0] p01,
  input  logic [PIX_W-1:0] p02,
  input  logic [PIX_W-1:0] p10,
  input  logic [PIX_W-1:0] p12,
  input  logic [PIX_W-1:0] p20,
  input  logic [PIX_W-1:0] p21,
  input  logic [PIX_W-1:0] p22,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] result
);

  localparam int GW = grad_width(PIX_W);

  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic [31:0]          mag;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return {{(GW-PIX_W){1'b0}}, p};
  endfunction

  // The centre pixel carries zero weight in both kernels, so it is not an input.
  always_comb begin
    gx     = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
    gy     = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
    mag    = sat_abs_sum(32'(gx), 32'(gy), PIX_W);
    result = mag[PIX_W-1:0];
    if (mode == MODE_THR) begin
      result = (mag >= 32'(thresh)) ? '1 : '0;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with line buffers and valid/ready
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   in_valid/in_ready/in_pixel    raster-order pixel input, frame after frame
//   out_valid/out_ready/out_pixel one result per interior pixel, registered
//   out_last                      final result of a frame
//   mode, thresh                  output mode and threshold, sampled on the producing accept
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  // Only the two older window columns are stored; the newest column is the live
  // {lb2[col], lb1[col], in_pixel}, so the kernel sees the full window on the accept itself.
  logic [PIX_W-1:0] w_top [2];
  logic [PIX_W-1:0] w_mid [2];
  logic [PIX_W-1:0] w_bot [2];

  logic [PIX_W-1:0] c_top;
  logic [PIX_W-1:0] c_mid;
  logic             accept;
  logic             produce;
  logic             frame_end;
  logic [PIX_W-1:0] kernel_out;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign c_top     = lb2[col];
  assign c_mid     = lb1[col];
  assign produce   = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_end = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers are never read before being written in the current frame, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= in_pixel;
      lb2[col] <= lb1[col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_top <= '{default: '0};
      w_mid <= '{default: '0};
      w_bot <= '{default: '0};
    end else if (accept) begin
      w_top <= '{w_top[1], c_top};
      w_mid <= '{w_mid[1], c_mid};
      w_bot <= '{w_bot[1], in_pixel};
    end
  end

  sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
    .p00    (w_top[0]),
    .p01    (w_top[1]),
    .p02    (c_top),
    .p10    (w_mid[0]),
    .p12    (c_mid),
    .p20    (w_bot[0]),
    .p21    (w_bot[1]),
    .p22    (in_pixel),
    .mode   (mode),
    .thresh (thresh),
    .result (kernel_out)
  );

  // An accept implies the register is free (empty or being drained this cycle),
  // so it is either reloaded or cleared; otherwise a drain clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (accept && produce) begin
      out_valid <= 1'b1;
      out_pixel <= kernel_out;
      out_last  <= frame_end;
    end else if (accept || out_ready) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - self-checking bench for sobel_stream with a frame-level reference model
module tb_sobel_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  typedef logic [7:0] frame_t [W*H];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;
  logic       out_last;
  logic       mode = 1'b0;
  logic [7:0] thresh = '0;

  exp_t exp_q[$];
  exp_t mdl_q[$];

  int checks = 0;
  int failures = 0;
  int acc_since_rst = 0;
  int first_out_at = -1;
  int out_cnt = 0;

  int pin_edge[4]      = '{0, 40, 0, 40};
  int pin_edge_thr[4]  = '{0, 255, 0, 255};
  int pin_last[4]      = '{0, 0, 0, 1};

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_last  (out_last),
    .mode      (mode),
    .thresh    (thresh)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int px(input frame_t f, input int r, input int c);
    return int'(f[r*W + c]);
  endfunction

  // Reference: evaluate every interior pixel of a whole frame in raster order.
  function automatic void model_frame(input frame_t f, input logic md, input int th);
    mdl_q.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        int gx;
        int gy;
        int mag;
        int val;
        exp_t e;
        gx = (px(f, r-1, c+1) + 2*px(f, r, c+1) + px(f, r+1, c+1))
           - (px(f, r-1, c-1) + 2*px(f, r, c-1) + px(f, r+1, c-1));
        gy = (px(f, r+1, c-1) + 2*px(f, r+1, c) + px(f, r+1, c+1))
           - (px(f, r-1, c-1) + 2*px(f, r-1, c) + px(f, r-1, c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        val = md ? ((mag >= th) ? 255 : 0) : mag;
        e.pix  = 8'(val);
        e.last = (r == H - 2) && (c == W - 2);
        mdl_q.push_back(e);
      end
    end
  endfunction

  function automatic frame_t rows_of(input int a, input int b, input int c, input int d);
    frame_t f;
    for (int r = 0; r < H; r++) begin
      f[r*W + 0] = 8'(a);
      f[r*W + 1] = 8'(b);
      f[r*W + 2] = 8'(c);
      f[r*W + 3] = 8'(d);
    end
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < W*H; i++) f[i] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  task automatic send_pix(input logic [7:0] p, input bit gaps);
    int  n;
    bit  ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pixel = p;
    n = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n >= 200) begin
        chk("in_accept_timeout", n, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input logic md, input int th, input bit gaps);
    mode   = md;
    thresh = 8'(th);
    model_frame(f, md, th);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    for (int i = 0; i < W*H; i++) send_pix(f[i], gaps);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic stall_proc();
    int n;
    int a0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    chk("stall_saw_valid", out_valid, 1);
    out_ready = 1'b0;
    a0 = acc_since_rst;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      if (exp_q.size() > 0) chk("stall_out_pixel", out_pixel, exp_q[0].pix);
    end
    chk("stall_no_accept", acc_since_rst, a0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  // Single compare process: every output handshake is checked against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      acc_since_rst = 0;
      first_out_at  = -1;
    end else begin
      if (out_valid && first_out_at < 0) first_out_at = acc_since_rst;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'(out_pixel) + 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_pixel", out_pixel, e.pix);
          chk("out_last", out_last, e.last);
        end
      end
      if (out_ready) chk("in_ready_when_free", in_ready, 1);
      if (in_valid && in_ready) acc_since_rst++;
    end
  end

  initial begin
    int oc;

    // Pin the model against hand-computed values.
    model_frame(rows_of(0, 0, 0, 10), 1'b0, 0);
    for (int i = 0; i < 4; i++) chk("model_edge", mdl_q[i].pix, pin_edge[i]);
    for (int i = 0; i < 4; i++) chk("model_last", mdl_q[i].last, pin_last[i]);
    model_frame(rows_of(0, 0, 0, 10), 1'b1, 40);
    for (int i = 0; i < 4; i++) chk("model_edge_thr40", mdl_q[i].pix, pin_edge_thr[i]);
    model_frame(rows_of(0, 0, 255, 255), 1'b0, 0);
    for (int i = 0; i < 4; i++) chk("model_sat", mdl_q[i].pix, 255);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pixel", out_pixel, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    oc = out_cnt;
    run_frame(rows_of(50, 50, 50, 50), 1'b0, 0, 1'b0);
    drain();
    chk("const_out_count", out_cnt - oc, 4);

    run_frame(rows_of(0, 0, 0, 10), 1'b0, 0, 1'b0);
    run_frame(rows_of(0, 0, 0, 10), 1'b1, 41, 1'b0);
    run_frame(rows_of(0, 0, 0, 10), 1'b1, 40, 1'b0);
    drain();

    run_frame(rows_of(0, 0, 255, 255), 1'b0, 0, 1'b0);
    drain();

    oc = out_cnt;
    fork
      run_frame(rows_of(0, 0, 0, 10), 1'b0, 0, 1'b0);
      stall_proc();
    join
    drain();
    chk("stall_out_count", out_cnt - oc, 4);

    for (int i = 0; i < 7; i++) send_pix(8'd50, 1'b0);
    do_reset();
    oc = out_cnt;
    run_frame(rows_of(50, 50, 50, 50), 1'b0, 0, 1'b0);
    drain();
    chk("reset_first_out_after_accepts", first_out_at, 11);
    chk("reset_out_count", out_cnt - oc, 4);

    oc = out_cnt;
    run_frame(rand_frame(), 1'b0, 0, 1'b1);
    run_frame(rand_frame(), 1'b0, 0, 1'b1);
    drain();
    chk("two_frame_out_count", out_cnt - oc, 8);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming 3×3 Sobel edge detector that takes a raster-order pixel stream and emits the gradient magnitude for every interior pixel of each frame. Two internal line buffers build the 3×3 window on the fly, so each pixel is supplied once instead of as a pre-assembled 72-bit window. Image size and pixel width are parametrised. A runtime mode selects saturated magnitude or binary threshold output. Valid/ready handshakes on both sides let it sit between the frame memory reader and the display/output writer.

## Interface
- PIX_W, 8, pixel width in bits
- IMG_W, 100, pixels per row (≥3)
- IMG_H, 100, rows per frame (≥3)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block accepts in_pixel this cycle
- in_pixel  in  PIX_W  next pixel, raster order, frame after frame
- out_valid  out  1  out_pixel is valid
- out_ready  in  1  downstream accepts out_pixel
- out_pixel  out  PIX_W  Sobel result for interior pixel
- out_last  out  1  marks the final output of a frame
- mode  in  1  0 = saturated magnitude, 1 = threshold
- thresh  in  PIX_W  threshold for mode 1

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accept.
  - col wraps to 0 and increments row.
  - row wraps to 0 after (IMG_W-1, IMG_H-1), which starts the next frame with no gap.
- Two line buffers, IMG_W×PIX_W each, hold rows r-1 and r-2 at column col. On accept they shift: lb1[col]←in_pixel, lb2[col]←old lb1[col].
- The 3×3 window shift register takes a column {lb2[col], lb1[col], in_pixel} on each accept.
- An accept at row≥2 and col≥2 completes the window centred at (row-1, col-1). That output is produced.
  - No output is produced for any other accept.
  - Each frame yields (IMG_W-2)×(IMG_H-2) outputs.
- Window p[r][c], r,c ∈ 0..2, top-left first:
  - Gx = (p02+2p12+p22) − (p00+2p10+p20)
  - Gy = (p20+2p21+p22) − (p00+2p01+p02)
  - Both are signed PIX_W+3 bits.
  - mag = |Gx|+|Gy|, saturated to 2^PIX_W−1.
- Mode 0 outputs mag. Mode 1 outputs all-ones if mag ≥ thresh, else 0.
- mode and thresh are sampled on the producing accept.
- out_last = 1 on the output produced by the accept at (IMG_W-1, IMG_H-1).
- Reset:
  - out_valid=0, out_pixel=0, out_last=0.
  - col=row=0, window cleared.
  - in_ready=1 from the first cycle after reset.
  - Line buffer contents are not cleared; they are never used before being rewritten.
- Reset mid-frame discards the partial frame and any pending output. The next accepted pixel is (0,0).

## Timing
- Latency is 1 cycle. The output register loads on the clock edge of the producing accept. out_valid rises the next cycle.
- out_pixel and out_last stay stable while out_valid && !out_ready.
- While stalled, in_ready=0. No input is accepted and counters and buffers freeze.
- When out_valid && out_ready && accept fall in the same cycle, the register is overwritten (if the accept produces an output) or cleared (if not). Full throughput is 1 pixel/cycle.
- Line buffer read is combinational, or synchronous with bypass. Either way, the accepted column must reflect all prior accepts.
- in_valid may drop at any time with no effect on state.

## Structure
- Package sobel_pkg holds:
  - the PIX_W-derived gradient width, GRAD_W = PIX_W+3
  - MODE_MAG/MODE_THR constants
  - the saturating absolute-value function
- Sub-module sobel_kernel: combinational.
  - Inputs: the 9 window pixels, mode, thresh.
  - Output: the PIX_W result.
- The top level holds counters, line buffers, window and output handshake register.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, PIX_W=8 unless noted.
- Constant frame of 50, mode 0, out_ready=1 → exactly 4 outputs, all 0. out_last only on the 4th. in_ready is never low.
- Each row {0,0,0,10}, mode 0 → outputs in order 0,40,0,40. Mode 1 with thresh=41 → all 0. Mode 1 with thresh=40 → 0,255,0,255.
- Each row {0,0,255,255}, mode 0 → all outputs 255 (Gx=1020 saturates).
- Backpressure: out_ready low for 5 cycles while out_valid → out_pixel stable, in_ready=0, no pixels accepted. After release, the full 4-output sequence matches the unstalled run.
- Reset asserted after 7 pixels, then one full constant-50 frame → the first output appears only after pixel (2,2) of the new frame. No stale output appears.
- Two back-to-back frames with in_valid toggling randomly → 8 outputs total, out_last on outputs 4 and 8, values equal to a reference model.
